// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op encodings,
// FSM state type and default datapath width.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline and the multiply-divide unit.
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit_div_core.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and emit the next partial remainder and quotient.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // i_quo holds the not-yet-consumed dividend bits in its upper end.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_div});
    // When w_ge holds the true difference is below the divisor, so it fits WIDTH bits.
    assign w_diff  = w_shift[WIDTH-1:0] - i_div;

    assign o_rem = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply-divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional MDU_FAST_MUL_EN: single-cycle combinational MULT/MULTU.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    mult_div_unit_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    mdu_state_e       r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_is_div, w_is_div_nxt;
    logic             r_neg_q, w_neg_q_nxt;
    logic             r_neg_r, w_neg_r_nxt;
    logic             r_bzero, w_bzero_nxt;
    logic [WIDTH-1:0] r_acc_hi, w_acc_hi_nxt;
    logic [WIDTH-1:0] r_acc_lo, w_acc_lo_nxt;
    logic [WIDTH-1:0] r_opnd, w_opnd_nxt;
    logic [WIDTH-1:0] r_a_raw, w_a_raw_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic             r_done, w_done_nxt;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_q_s;
    logic [WIDTH-1:0]   w_r_s;

    // Operands are reduced to magnitudes; signs are reapplied on the final edge.
    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -bus.a : bus.a;
    assign w_abs_b  = w_b_neg ? -bus.b : bus.b;

    // Shift-add multiply step: acc_hi accumulates, acc_lo shifts out multiplier bits.
    assign w_add    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_hi = w_add[WIDTH:1];
    assign w_mul_lo = {w_add[0], r_acc_lo[WIDTH-1:1]};
    assign w_prod   = {w_mul_hi, w_mul_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .i_rem(r_acc_hi),
        .i_quo(r_acc_lo),
        .i_div(r_opnd),
        .o_rem(w_div_rem),
        .o_quo(w_div_quo)
    );

    assign w_q_s = r_neg_q ? -w_div_quo : w_div_quo;
    assign w_r_s = r_neg_r ? -w_div_rem : w_div_rem;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_fast_prod;

    // Sign-extended operands make a modular unsigned multiply correct for MULT too.
    assign w_ext_a     = {{WIDTH{w_a_neg}}, bus.a};
    assign w_ext_b     = {{WIDTH{w_b_neg}}, bus.b};
    assign w_fast_prod = w_ext_a * w_ext_b;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_is_div_nxt = r_is_div;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_bzero_nxt  = r_bzero;
        w_acc_hi_nxt = r_acc_hi;
        w_acc_lo_nxt = r_acc_lo;
        w_opnd_nxt   = r_opnd;
        w_a_raw_nxt  = r_a_raw;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
`ifdef MDU_FAST_MUL_EN
                    if (!bus.op[1]) begin
                        w_hi_nxt   = w_fast_prod[2*WIDTH-1:WIDTH];
                        w_lo_nxt   = w_fast_prod[WIDTH-1:0];
                        w_done_nxt = 1'b1;
                    end else
`endif
                    begin
                        w_state_nxt  = RUN;
                        w_cnt_nxt    = CW'(WIDTH);
                        w_is_div_nxt = bus.op[1];
                        w_neg_q_nxt  = w_a_neg ^ w_b_neg;
                        w_neg_r_nxt  = w_a_neg;
                        w_bzero_nxt  = (bus.b == '0);
                        w_a_raw_nxt  = bus.a;
                        w_acc_hi_nxt = '0;
                        w_acc_lo_nxt = bus.op[1] ? w_abs_a : w_abs_b;
                        w_opnd_nxt   = bus.op[1] ? w_abs_b : w_abs_a;
                    end
                end else begin
                    if (bus.mthi) w_hi_nxt = bus.wdata;
                    if (bus.mtlo) w_lo_nxt = bus.wdata;
                end
            end

            RUN: begin
                w_cnt_nxt    = r_cnt - CW'(1);
                w_acc_hi_nxt = r_is_div ? w_div_rem : w_mul_hi;
                w_acc_lo_nxt = r_is_div ? w_div_quo : w_mul_lo;
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    if (!r_is_div) begin
                        w_hi_nxt = w_prod_s[2*WIDTH-1:WIDTH];
                        w_lo_nxt = w_prod_s[WIDTH-1:0];
                    end else if (r_bzero) begin
                        w_hi_nxt = r_a_raw;
                        w_lo_nxt = '1;
                    end else begin
                        w_hi_nxt = w_r_s;
                        w_lo_nxt = w_q_s;
                    end
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_a_raw  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_div <= w_is_div_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_bzero  <= w_bzero_nxt;
            r_acc_hi <= w_acc_hi_nxt;
            r_acc_lo <= w_acc_lo_nxt;
            r_opnd   <= w_opnd_nxt;
            r_a_raw  <= w_a_raw_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_mult_div_unit;

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // {hi, lo} an operation must produce, from plain arithmetic.
    function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: r = sa * sb;
            2'b01: r = {32'd0, a} * {32'd0, b};
            2'b10: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                   else r = {32'(sa % sb), 32'(sa / sb)};
            default: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                     else r = {a % b, a / b};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle-level timing from the interface rules, results from ref_calc.
    logic [31:0] m_hi, m_lo;
    logic        m_done;
    int          m_left;
    logic [63:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end
            end else if (bus.start) begin
                if (FAST && !bus.op[1]) begin
                    {m_hi, m_lo} <= ref_calc(bus.op, bus.a, bus.b);
                    m_done       <= 1'b1;
                end else begin
                    m_res  <= ref_calc(bus.op, bus.a, bus.b);
                    m_left <= 32;
                end
            end else begin
                if (bus.mthi) m_hi <= bus.wdata;
                if (bus.mtlo) m_lo <= bus.wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_hi", {32'd0, bus.hi}, {32'd0, m_hi});
            chk("cyc_lo", {32'd0, bus.lo}, {32'd0, m_lo});
            chk("cyc_busy", {63'd0, bus.busy}, {63'd0, m_left > 0});
            chk("cyc_done", {63'd0, bus.done}, {63'd0, m_done});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and watch busy/done across the whole latency window.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int bcnt, output int dcnt);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            bcnt += int'(bus.busy);
            dcnt += int'(bus.done);
        end
        if (dcnt == 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done pulse, required 1");
        end
        tick();
    endtask

    int bc, dc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;

        // Pin the reference model itself against hand-computed results.
        chk("ref_multu", ref_calc(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("ref_mult", ref_calc(2'b00, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("ref_div", ref_calc(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("ref_ovf", ref_calc(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        tick();

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
        chk("multu_res", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        chk("multu_busy_cycles", 64'(bc), FAST ? 64'd0 : 64'd32);
        chk("multu_done_pulses", 64'(dc), 64'd1);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, bc, dc);
        chk("mult_res", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_busy_cycles", 64'(bc), FAST ? 64'd0 : 64'd32);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, bc, dc);
        chk("div_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_busy_cycles", 64'(bc), 64'd32);
        run_op(2'b11, 32'd7, 32'd2, bc, dc);
        chk("divu", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
        run_op(2'b10, 32'h1234_5678, 32'd0, bc, dc);
        chk("div_by_zero", {bus.hi, bus.lo}, 64'h1234_5678_FFFF_FFFF);
        chk("div_by_zero_busy", 64'(bc), 64'd32);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
        chk("div_overflow", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        bus.mthi  = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        tick();
        bus.mthi = 1'b0;
        @(negedge clk);
        chk("idle_mthi", {bus.hi, bus.lo}, 64'hA5A5_A5A5_8000_0000);
        tick();

        bus.mtlo  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        run_op(2'b11, 32'd7, 32'd2, bc, dc);
        chk("start_beats_mtlo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);

        // mthi and a second start arriving mid-division must both be dropped.
        bus.op    = 2'b11;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.mthi  = 1'b1;
        bus.wdata = 32'h1111_1111;
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        tick();
        bus.mthi  = 1'b0;
        bus.start = 1'b0;
        dc = 0;
        for (int i = 0; i < 40 && dc == 0; i++) begin
            @(negedge clk);
            dc += int'(bus.done);
        end
        chk("busy_ignore_done", 64'(dc), 64'd1);
        chk("busy_ignore_res", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);
        tick();

        // Asynchronous reset in the middle of a DIVU.
        bus.op    = 2'b11;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("async_rst_done", {63'd0, bus.done}, 64'd0);
        chk("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(2'b01, 32'd3, 32'd4, bc, dc);
        chk("post_rst_op", {bus.hi, bus.lo}, 64'h0000_0000_0000_000C);
        chk("post_rst_done", 64'(dc), 64'd1);

        // Randomized traffic, checked cycle by cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 9) == 0);
            bus.op    = 2'($urandom_range(0, 3));
            bus.a     = pick();
            bus.b     = pick();
            bus.mthi  = ($urandom_range(0, 3) == 0);
            bus.mtlo  = ($urandom_range(0, 3) == 0);
            bus.wdata = $urandom;
            tick();
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        repeat (40) tick();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply-divide unit for the MIPS core; executes MULT, MULTU, DIV and DIVU, and holds the architectural HI and LO registers.
- Its hi/lo outputs feed the 4-way 32-bit write-back/result selector that serves MFHI/MFLO.
- busy is the stall request to the pipeline hazard logic.

Parameters:
- WIDTH, 32: operand and HI/LO width; the iterative operation takes WIDTH cycles.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin the operation in op.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand: multiplicand, or dividend for DIV/DIVU.
- b  in  WIDTH  rt operand: multiplier, or divisor for DIV/DIVU.
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO take a new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: asynchronous on rst_n low. hi=0, lo=0, busy=0, done=0, counter=0, FSM=IDLE. Reset mid-operation aborts the operation and discards any partial result.
- FSM states:
  - IDLE: start=1 captures op, |a|, |b| and the result signs, loads counter=WIDTH, sets busy=1 and moves to RUN.
  - RUN: performs one shift-add (multiply) or restoring shift-subtract (divide) step per cycle and decrements the counter.
  - When the counter reaches 1: that edge writes hi/lo, clears busy, sets done=1 and returns to IDLE.
- Latency: start sampled at edge E0; busy=1 from after E0 until E32; result visible and done=1 after E32; done clears after E33.
- Multiply: 64-bit product with HI = upper half and LO = lower half. MULT is signed two's-complement; MULTU is unsigned.
- Divide: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
- Divide by zero: LO=all ones, HI=a. The operation still takes the full WIDTH cycles.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Operands are captured at start and are don't-care afterwards.
- start while busy: ignored. The pipeline must stall on busy.
- mthi/mtlo:
  - While idle, they update the register at the next edge.
  - Both may be asserted together.
  - They are ignored while busy.
  - They are ignored in a cycle where start is accepted, because start has priority.
- hi/lo are unchanged during RUN until the final edge.
- done never asserts for mthi/mtlo.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: MULT/MULTU complete in a single cycle using a combinational multiplier. hi/lo update at E0, done=1 after E0, busy is never asserted. DIV/DIVU are unchanged.
- Undefined: all four ops use the iterative WIDTH-cycle path described above.

Decomposition:
- Shared package mdu_pkg holds:
  - the op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the FSM state typedef (IDLE, RUN);
  - the default width constant 32.
- One sub-module, mdu_div_core, is natural. It performs a single restoring-division step: partial remainder and quotient in, next values out, combinational. It is instantiated once in the RUN datapath.
- Sign handling and the multiply step stay in the top module.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 32 cycles hi=0xFFFFFFFE, lo=0x00000001; exactly one done pulse; busy high for exactly 32 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). With MDU_FAST_MUL_EN the same values appear 1 cycle after start, with busy never high.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1.
- DIV a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Idle mthi wdata=0xA5A5A5A5 -> hi=0xA5A5A5A5 and lo unchanged. start together with mtlo -> mtlo dropped. mthi or a new start while busy -> ignored, and the original result is intact.
- Assert rst_n=0 at cycle 10 of a DIVU -> busy=0, done=0, hi=lo=0 immediately without waiting for a clock edge. A fresh start after reset release completes normally.
